// File: rtl/w_tile_controller.sv
// Weight-side tile sequencer for the systolic array.
// Per tile: clear the shadow weight buffer, load ROWS rows from weight memory,
// wait for the IF controller to go idle, swap shadow/active buffers, then kick
// the IF pass. The next tile loads while the current one streams.
//
// Optional build macro W_TILE_CTRL_STALL_CNT_EN adds a saturating stall_cnt
// output counting LOAD cycles without w_valid and WAIT_SW cycles without
// if_ready.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start, ready=1
// CLR     | one-cycle clear of the shadow weight buffer
// LOAD    | popping weight rows while w_valid is high
// WAIT_SW | shadow buffer full, waiting for the IF controller to idle
// SWITCH  | one-cycle swap of shadow and active buffers
// STRT    | one-cycle start of the IF pass on the new active tile
// DRAIN   | last tile issued, waiting for the final IF pass to finish
// FIN     | one-cycle job-complete pulse

module w_tile_controller #(
    parameter int ROWS   = 16,
    parameter int TILE_W = 8,
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [TILE_W-1:0] num_tiles,
    input  logic              w_valid,
    input  logic              if_ready,
    output logic              w_read,
    output logic              clr_w,
    output logic              switch,
    output logic              start_if,
    output logic              ready,
    output logic              done,
    output logic [ROW_W-1:0]  row_idx,
    output logic [TILE_W-1:0] tile_idx
`ifdef W_TILE_CTRL_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLR     = 3'd1,
        LOAD    = 3'd2,
        WAIT_SW = 3'd3,
        SWITCH  = 3'd4,
        STRT    = 3'd5,
        DRAIN   = 3'd6,
        FIN     = 3'd7
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [TILE_W-1:0] num_tiles_q;
    logic              last_row;
    logic              last_tile;

    // Row and tile counters stop at their last value, so they never wrap.
    assign last_row  = (row_idx == ROW_W'(ROWS - 1));
    assign last_tile = (tile_idx == (num_tiles_q - TILE_W'(1)));

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and output decode; pulses come straight from the registered state.
    always_comb begin
        state_nxt = state;
        w_read    = 1'b0;
        clr_w     = 1'b0;
        switch    = 1'b0;
        start_if  = 1'b0;
        ready     = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_nxt = (num_tiles == '0) ? FIN : CLR;
                end
            end
            CLR: begin
                clr_w     = 1'b1;
                state_nxt = LOAD;
            end
            LOAD: begin
                w_read = w_valid;
                if (w_valid && last_row) begin
                    state_nxt = WAIT_SW;
                end
            end
            WAIT_SW: begin
                if (if_ready) begin
                    state_nxt = SWITCH;
                end
            end
            SWITCH: begin
                switch    = 1'b1;
                state_nxt = STRT;
            end
            STRT: begin
                // if_ready is deliberately ignored here: it may still read high
                // in the same cycle the IF pass is being kicked.
                start_if  = 1'b1;
                state_nxt = last_tile ? DRAIN : CLR;
            end
            DRAIN: begin
                if (if_ready) begin
                    state_nxt = FIN;
                end
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Job length latch plus row/tile counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            num_tiles_q <= '0;
            tile_idx    <= '0;
            row_idx     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        num_tiles_q <= num_tiles;
                        tile_idx    <= '0;
                    end
                end
                CLR: begin
                    row_idx <= '0;
                end
                LOAD: begin
                    if (w_valid && !last_row) begin
                        row_idx <= row_idx + ROW_W'(1);
                    end
                end
                STRT: begin
                    if (!last_tile) begin
                        tile_idx <= tile_idx + TILE_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef W_TILE_CTRL_STALL_CNT_EN
    logic stall_evt;

    assign stall_evt = ((state == LOAD) && !w_valid) ||
                       ((state == WAIT_SW) && !if_ready);

    // Saturating stall counter, restarted for every accepted job.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if ((state == IDLE) && start) begin
            stall_cnt <= '0;
        end else if (stall_evt && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_w_tile_controller.sv
// Directed bench for w_tile_controller (ROWS=4, TILE_W=8) with an event
// scoreboard. Each job pushes its expected pulse sequence; a negedge monitor
// pops and compares every pulse the DUT emits. A small IF/weight-memory model
// drives if_ready and w_valid just after each rising edge.

module tb_w_tile_controller;

    localparam int ROWS   = 4;
    localparam int TILE_W = 8;

    localparam logic [2:0] K_CLR  = 3'd1;
    localparam logic [2:0] K_READ = 3'd2;
    localparam logic [2:0] K_SW   = 3'd3;
    localparam logic [2:0] K_SI   = 3'd4;
    localparam logic [2:0] K_DONE = 3'd5;

    typedef struct packed {
        logic [2:0] kind;
        logic [7:0] tile;
        logic [1:0] row;
    } ev_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] num_tiles;
    logic       w_valid;
    logic       if_ready;
    logic       w_read;
    logic       clr_w;
    logic       switch;
    logic       start_if;
    logic       ready;
    logic       done;
    logic [1:0] row_idx;
    logic [7:0] tile_idx;
`ifdef W_TILE_CTRL_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int   checks = 0;
    int   errors = 0;
    ev_t  exp_q[$];
    int   busy_q[$];
    int   cnt[6];
    logic wv_toggle = 1'b0;
    logic prev_ifr  = 1'b1;

    w_tile_controller #(
        .ROWS  (ROWS),
        .TILE_W(TILE_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .num_tiles(num_tiles),
        .w_valid  (w_valid),
        .if_ready (if_ready),
        .w_read   (w_read),
        .clr_w    (clr_w),
        .switch   (switch),
        .start_if (start_if),
        .ready    (ready),
        .done     (done),
        .row_idx  (row_idx),
        .tile_idx (tile_idx)
`ifdef W_TILE_CTRL_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_stall(input string tag, input int exp);
`ifdef W_TILE_CTRL_STALL_CNT_EN
        chk(tag, 64'(stall_cnt), 64'(exp));
`endif
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_pulses"}, {58'd0, ready, w_read, clr_w, switch, start_if, done}, 64'b100000);
        chk({tag, "_row_idx"}, 64'(row_idx), 64'd0);
        chk({tag, "_tile_idx"}, 64'(tile_idx), 64'd0);
        chk_stall({tag, "_stall"}, 0);
    endtask

    function automatic ev_t mk(input logic [2:0] k, input int t, input int r);
        ev_t e;
        e.kind = k;
        e.tile = t[7:0];
        e.row  = r[1:0];
        return e;
    endfunction

    task automatic push_job(input int n);
        for (int t = 0; t < n; t++) begin
            exp_q.push_back(mk(K_CLR, t, 0));
            for (int r = 0; r < ROWS; r++) exp_q.push_back(mk(K_READ, t, r));
            exp_q.push_back(mk(K_SW, t, 0));
            exp_q.push_back(mk(K_SI, t, 0));
        end
        exp_q.push_back(mk(K_DONE, (n == 0) ? 0 : n - 1, 0));
    endtask

    // Weight memory and IF controller model, driven just after each rising edge.
    initial begin
        int  busy;
        logic prev_tog;
        busy     = 0;
        prev_tog = 1'b0;
        w_valid  = 1'b1;
        if_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (wv_toggle) w_valid = prev_tog ? ~w_valid : 1'b0;
            else           w_valid = 1'b1;
            prev_tog = wv_toggle;
            if (start_if) begin
                if_ready = 1'b0;
                busy     = (busy_q.size() > 0) ? busy_q.pop_front() : 3;
            end else if (busy > 0) begin
                busy--;
            end else begin
                if_ready = 1'b1;
            end
        end
    end

    // Scoreboard monitor: every emitted pulse must match the head of exp_q.
    always @(negedge clk) begin
        logic [2:0] kind;
        ev_t        got;
        ev_t        want;
        if (rst) begin
            kind = 3'd0;
            if (clr_w)    kind = K_CLR;
            if (w_read)   kind = K_READ;
            if (switch)   kind = K_SW;
            if (start_if) kind = K_SI;
            if (done)     kind = K_DONE;
            if (kind != 3'd0) begin
                cnt[kind]++;
                got.kind = kind;
                got.tile = tile_idx;
                got.row  = (kind == K_READ) ? row_idx : 2'b00;
                want     = (exp_q.size() > 0) ? exp_q.pop_front() : 13'h0;
                checks++;
                assert (got === want) else begin
                    errors++;
                    $error("FAIL sb_event observed=%0h expected=%0h", got, want);
                end
            end
            if (switch) begin
                checks++;
                assert (prev_ifr === 1'b1) else begin
                    errors++;
                    $error("FAIL switch_without_if_ready observed=%0b expected=1", prev_ifr);
                end
            end
            prev_ifr = if_ready;
        end
    end

    task automatic run_job(input int n, input logic tog, input int budget, output int lat);
        int c;
        int d0;
        d0  = cnt[K_DONE];
        lat = -1;
        c   = 0;
        push_job(n);
        @(negedge clk);
        start     = 1'b1;
        num_tiles = n[7:0];
        wv_toggle = tog;
        while (lat < 0 && c < budget) begin
            @(negedge clk);
            #1;
            c++;
            if (c == 1) begin
                start     = 1'b0;
                num_tiles = 8'hAA;
            end
            if (cnt[K_DONE] != d0) lat = c;
        end
        wv_toggle = 1'b0;
        chk("job_done_seen", 64'(lat > 0), 64'd1);
        @(negedge clk);
        #1;
        chk("ready_after_done", 64'(ready), 64'd1);
        chk("sb_drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int         lat;
        int         c0[6];
        logic [5:0] exp_v;
        int         c;

        for (int i = 0; i < 6; i++) cnt[i] = 0;
        rst       = 1'b0;
        start     = 1'b0;
        num_tiles = 8'd0;
        repeat (2) @(negedge clk);
        #1;
        chk_reset_outputs("reset");
        #2;
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Cycle-accurate single tile; num_tiles changes after the latch.
        push_job(1);
        start     = 1'b1;
        num_tiles = 8'd1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            #1;
            if (k == 1) begin
                start     = 1'b0;
                num_tiles = 8'd5;
            end
            exp_v = {k == 1, (k >= 2) && (k <= 5), k == 7, k == 8, k == 13, k == 14};
            chk($sformatf("t1_cyc%0d", k), {58'd0, clr_w, w_read, switch, start_if, done, ready},
                64'(exp_v));
        end
        chk("t1_sb_drained", 64'(exp_q.size()), 64'd0);
        chk("t1_row_idx_hold", 64'(row_idx), 64'd3);

        // w_valid toggling: exactly ROWS reads, three stalls.
        c0 = cnt;
        run_job(1, 1'b1, 60, lat);
        chk("tog_reads", 64'(cnt[K_READ] - c0[K_READ]), 64'd4);
        chk("tog_row_idx_no_wrap", 64'(row_idx), 64'd3);
        chk_stall("tog_stall", 3);

        // Three tiles, IF busy for 20 cycles after the first start_if.
        busy_q.push_back(20);
        c0 = cnt;
        run_job(3, 1'b0, 200, lat);
        chk("t3_clr", 64'(cnt[K_CLR] - c0[K_CLR]), 64'd3);
        chk("t3_switch", 64'(cnt[K_SW] - c0[K_SW]), 64'd3);
        chk("t3_start_if", 64'(cnt[K_SI] - c0[K_SI]), 64'd3);
        chk("t3_done", 64'(cnt[K_DONE] - c0[K_DONE]), 64'd1);
        chk("t3_tile_idx_last", 64'(tile_idx), 64'd2);
        chk_stall("t3_stall", 15);

        // Empty job.
        c0 = cnt;
        run_job(0, 1'b0, 10, lat);
        chk("t0_latency", 64'(lat), 64'd1);
        chk("t0_no_loads", 64'(cnt[K_CLR] + cnt[K_READ] + cnt[K_SW] - c0[K_CLR] - c0[K_READ] - c0[K_SW]),
            64'd0);
        chk_stall("t0_stall", 0);

        // Reset during LOAD of tile 1, then a clean two-tile restart.
        c0 = cnt;
        push_job(2);
        @(negedge clk);
        start     = 1'b1;
        num_tiles = 8'd2;
        c = 0;
        while ((cnt[K_READ] - c0[K_READ]) < 6 && c < 60) begin
            @(negedge clk);
            #1;
            c++;
            start = 1'b0;
        end
        chk("abort_reached_tile1_load", 64'(cnt[K_READ] - c0[K_READ]), 64'd6);
        #2;
        rst = 1'b0;
        #1;
        chk_reset_outputs("abort");
        exp_q.delete();
        busy_q.delete();
        repeat (2) @(negedge clk);
        #1;
        chk_reset_outputs("abort_hold");
        #2;
        rst = 1'b1;
        c = 0;
        while (if_ready !== 1'b1 && c < 50) begin
            @(negedge clk);
            c++;
        end
        chk("if_idle_before_restart", 64'(if_ready), 64'd1);
        busy_q.push_back(10);
        c0 = cnt;
        run_job(2, 1'b0, 100, lat);
        chk("rs_clr", 64'(cnt[K_CLR] - c0[K_CLR]), 64'd2);
        chk("rs_start_if", 64'(cnt[K_SI] - c0[K_SI]), 64'd2);
        chk("rs_done", 64'(cnt[K_DONE] - c0[K_DONE]), 64'd1);
        chk_stall("rs_stall", 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
